// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared encodings and control-word type for the RV32I pipeline
package rv_pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam int               ALU_CTRL_W = 5;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 5'b00000;

  typedef struct packed {
    logic                  reg_write;
    logic [1:0]            result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  alu_src;
    logic                  valid;
  } ctrl_t;

  // Only beq/bne are resolved here; other branch conditions never redirect.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - decode-to-execute bundle between controller/datapath and the ID/EX register
interface id_ex_reg_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  import rv_pipe_pkg::*;

  logic                  StallE, FlushE, ZeroE;
  logic                  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD;
  logic [1:0]            ResultSrcD;
  logic [ALU_CTRL_W-1:0] ALUControlD;
  logic [2:0]            funct3D;
  logic [XLEN-1:0]       RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REGW-1:0]       Rs1D, Rs2D, RdD;

  logic                  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]            ResultSrcE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic [2:0]            funct3E;
  logic [XLEN-1:0]       RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [REGW-1:0]       Rs1E, Rs2E, RdE;
  logic                  PCSrcE, LoadE;

  modport master (
    output StallE, FlushE, ZeroE,
    output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, ResultSrcD, ALUControlD,
    output funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE,
    input  funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, PCSrcE, LoadE
  );

  modport slave (
    input  StallE, FlushE, ZeroE,
    input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, ResultSrcD, ALUControlD,
    input  funct3D, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, ResultSrcE, ALUControlE,
    output funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, PCSrcE, LoadE
  );

endinterface

// File: rtl/id_ex_reg_pipe_reg.sv
// rtl/id_ex_reg_pipe_reg.sv - generic pipeline register with async reset, sync clear and enable
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clr beats en so a flush overrides a concurrent stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, valid gating and branch resolution
module id_ex_reg
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_reg_if.slave  bus
);

  localparam int DATA_W = 5 * XLEN + 3 * REGW + 3;

  ctrl_t             ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // An invalid decode slot loads a bubble control word so it can never write state.
  always_comb begin
    ctrl_d             = '0;
    ctrl_d.result_src  = RES_ALU;
    ctrl_d.alu_control = ALU_ADD;
    if (bus.ValidD) begin
      ctrl_d.reg_write   = bus.RegWriteD;
      ctrl_d.result_src  = bus.ResultSrcD;
      ctrl_d.mem_write   = bus.MemWriteD;
      ctrl_d.jump        = bus.JumpD;
      ctrl_d.branch      = bus.BranchD;
      ctrl_d.alu_control = bus.ALUControlD;
      ctrl_d.alu_src     = bus.ALUSrcD;
      ctrl_d.valid       = 1'b1;
    end
  end

  assign data_d = {bus.RD1D, bus.RD2D, bus.ImmExtD, bus.PCD, bus.PCPlus4D,
                   bus.Rs1D, bus.Rs2D, bus.RdD, bus.funct3D};

  pipe_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.StallE),
    .clr   (bus.FlushE),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg #(.W(DATA_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.StallE),
    .clr   (bus.FlushE),
    .d     (data_d),
    .q     (data_q)
  );

  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.ALUControlE = ctrl_q.alu_control;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ValidE      = ctrl_q.valid;

  assign {bus.RD1E, bus.RD2E, bus.ImmExtE, bus.PCE, bus.PCPlus4E,
          bus.Rs1E, bus.Rs2E, bus.RdE, bus.funct3E} = data_q;

  // Redirect follows ZeroE combinationally, even while the register is stalled.
  assign bus.PCSrcE = ctrl_q.valid &
                      (ctrl_q.jump | (ctrl_q.branch & branch_taken(data_q[2:0], bus.ZeroE)));
  assign bus.LoadE  = ctrl_q.valid & (ctrl_q.result_src == RES_MEM);

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;
  import rv_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  id_ex_reg_if #(.XLEN(32), .REGW(5)) bus ();

  id_ex_reg #(.XLEN(32), .REGW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    bus.RegWriteD = 0; bus.MemWriteD = 0; bus.JumpD = 0; bus.BranchD = 0; bus.ALUSrcD = 0;
    bus.ValidD = 0; bus.ResultSrcD = RES_ALU; bus.ALUControlD = ALU_ADD; bus.funct3D = F3_BEQ;
    bus.RD1D = 0; bus.RD2D = 0; bus.ImmExtD = 0; bus.PCD = 0; bus.PCPlus4D = 0;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0;
  endtask

  initial begin
    bus.StallE = 0; bus.FlushE = 0; bus.ZeroE = 0;
    clear_d();
    #1;
    check_eq("reset_valid", bus.ValidE, 0);
    check_eq("reset_pcsrc", bus.PCSrcE, 0);

    // Fill E with nonzero state, then assert reset mid-cycle.
    bus.RegWriteD = 1; bus.MemWriteD = 1; bus.JumpD = 1; bus.ALUSrcD = 1; bus.ValidD = 1;
    bus.ResultSrcD = RES_MEM; bus.ALUControlD = 5'h1f; bus.RD1D = 32'hdead_beef;
    bus.RD2D = 32'h1234_5678; bus.PCD = 32'h100; bus.RdD = 5'd31;
    #6 rst_n = 1'b1;
    step();
    check_eq("pre_rst_rd", bus.RdE, 31);
    check_eq("pre_rst_pcsrc", bus.PCSrcE, 1);
    check_eq("pre_rst_load", bus.LoadE, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_rd", bus.RdE, 0);
    check_eq("async_rst_rd1", bus.RD1E, 0);
    check_eq("async_rst_regwrite", bus.RegWriteE, 0);
    check_eq("async_rst_valid", bus.ValidE, 0);
    check_eq("async_rst_pcsrc", bus.PCSrcE, 0);
    check_eq("async_rst_load", bus.LoadE, 0);
    #1 rst_n = 1'b1;

    // Pass-through with single-cycle latency.
    clear_d();
    bus.RdD = 5'd7; bus.RD1D = 32'h0000_00aa; bus.RegWriteD = 1; bus.ALUControlD = 5'b00001;
    bus.ValidD = 1;
    #1;
    check_eq("pass_before_edge", bus.RdE, 0);
    step();
    check_eq("pass_rd", bus.RdE, 7);
    check_eq("pass_rd1", bus.RD1E, 32'haa);
    check_eq("pass_regwrite", bus.RegWriteE, 1);
    check_eq("pass_aluctl", bus.ALUControlE, 5'b00001);
    check_eq("pass_valid", bus.ValidE, 1);

    // Stall holds for 3 edges, then stall+flush inserts a bubble.
    bus.RdD = 5'd9; bus.RD1D = 32'h55;
    bus.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_rd", bus.RdE, 7);
    end
    check_eq("stall_rd1", bus.RD1E, 32'haa);
    bus.FlushE = 1;
    step();
    check_eq("flush_rd", bus.RdE, 0);
    check_eq("flush_regwrite", bus.RegWriteE, 0);
    check_eq("flush_valid", bus.ValidE, 0);
    bus.StallE = 0; bus.FlushE = 0;

    // Branch resolution.
    clear_d();
    bus.BranchD = 1; bus.funct3D = F3_BEQ; bus.ValidD = 1;
    step();
    bus.ZeroE = 1; #1 check_eq("beq_taken", bus.PCSrcE, 1);
    bus.ZeroE = 0; #1 check_eq("beq_not_taken", bus.PCSrcE, 0);
    bus.funct3D = F3_BNE;
    step();
    bus.ZeroE = 0; #1 check_eq("bne_taken", bus.PCSrcE, 1);
    bus.ZeroE = 1; #1 check_eq("bne_not_taken", bus.PCSrcE, 0);
    bus.funct3D = 3'b100;
    step();
    bus.ZeroE = 1; #1 check_eq("f3_100_z1", bus.PCSrcE, 0);
    bus.ZeroE = 0; #1 check_eq("f3_100_z0", bus.PCSrcE, 0);

    // Jump, then the same jump in an invalid slot.
    clear_d();
    bus.JumpD = 1; bus.ResultSrcD = RES_PC4; bus.RegWriteD = 1; bus.RdD = 5'd1; bus.ValidD = 1;
    step();
    bus.ZeroE = 0; #1 check_eq("jal_z0", bus.PCSrcE, 1);
    bus.ZeroE = 1; #1 check_eq("jal_z1", bus.PCSrcE, 1);
    check_eq("jal_ressrc", bus.ResultSrcE, RES_PC4);
    bus.ValidD = 0;
    step();
    check_eq("inv_jump", bus.JumpE, 0);
    check_eq("inv_pcsrc", bus.PCSrcE, 0);
    check_eq("inv_regwrite", bus.RegWriteE, 0);
    check_eq("inv_valid", bus.ValidE, 0);
    check_eq("inv_ressrc", bus.ResultSrcE, RES_ALU);

    // Load flag, back-to-back flushes, recovery.
    clear_d();
    bus.ResultSrcD = RES_MEM; bus.RegWriteD = 1; bus.RdD = 5'd3; bus.ValidD = 1;
    step();
    check_eq("load_flag", bus.LoadE, 1);
    check_eq("load_rd", bus.RdE, 3);
    bus.FlushE = 1;
    step();
    check_eq("load_flushed", bus.LoadE, 0);
    step();
    check_eq("flush2_valid", bus.ValidE, 0);
    check_eq("flush2_rd", bus.RdE, 0);
    bus.FlushE = 0;
    step();
    check_eq("load_again", bus.LoadE, 1);

    // Reset asserted during a stall clears immediately.
    bus.StallE = 1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_in_stall_valid", bus.ValidE, 0);
    check_eq("rst_in_stall_rd", bus.RdE, 0);
    check_eq("rst_in_stall_load", bus.LoadE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
